// File: rtl/arb_mux21_2b_if.sv
// Bus bundle for the two-source round-robin mux front end.
// The master drives the source words; the slave (the arbiter) returns the popped stream and flags.
interface arb_mux21_2b_if;
  logic [1:0] in0;
  logic       in0_valid;
  logic [1:0] in1;
  logic       in1_valid;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_sel;
  logic       in0_full;
  logic       in1_full;
  logic       in0_drop;
  logic       in1_drop;

  modport master (
    output in0, in0_valid, in1, in1_valid,
    input  out_data, out_valid, out_sel, in0_full, in1_full, in0_drop, in1_drop
  );

  modport slave (
    input  in0, in0_valid, in1, in1_valid,
    output out_data, out_valid, out_sel, in0_full, in1_full, in0_drop, in1_drop
  );
endinterface

// File: rtl/arb_mux21_2b.sv
// Two-source round-robin front end for the 2-bit 2:1 mux: per-source FIFOs,
// a bounded-burst arbiter and registered data/valid/select outputs.
//
// state    | meaning
// S_IDLE   | both FIFOs were empty at the last decision; no pop
// S_GRANT0 | FIFO 0 pops one word per cycle
// S_GRANT1 | FIFO 1 pops one word per cycle
module arb_mux21_2b #(
  parameter int DEPTH = 4,
  parameter int BURST = 2
) (
  input  logic          clk,
  input  logic          reset,
  arb_mux21_2b_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = DEPTH + 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT    = CW'(1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [BW-1:0] burst_q, burst_d;

  logic [1:0]    mem_q    [2][DEPTH];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [CW-1:0] cnt_q    [2];
  logic [1:0]    drop_q;

  logic [1:0]    out_data_q;
  logic          out_valid_q;
  logic          out_sel_q;

  logic [1:0]    wvalid;
  logic [1:0]    wdata [2];
  logic [1:0]    full;
  logic [1:0]    nonempty;
  logic [1:0]    wr_en;
  logic [1:0]    pop;

  logic          gnt_src;
  logic          other_ne;
  logic          last_word;
  logic          burst_end;

  assign wvalid   = {bus.in1_valid, bus.in0_valid};
  assign wdata[0] = bus.in0;
  assign wdata[1] = bus.in1;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      full[s]     = (cnt_q[s] == FULL_CNT);
      nonempty[s] = (cnt_q[s] != '0);
      // A write into a full FIFO is lost even if the same edge pops it.
      wr_en[s]    = wvalid[s] & ~full[s];
    end
  end

  assign gnt_src   = (state_q == S_GRANT1);
  assign other_ne  = nonempty[~gnt_src];
  assign last_word = (cnt_q[gnt_src] == ONE_CNT);
  assign burst_end = (burst_q == BURST_LAST);

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (wr_en[s]) begin
        mem_q[s][wr_ptr_q[s]] <= wdata[s];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      drop_q <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (wr_en[s]) begin
          wr_ptr_q[s] <= wr_ptr_q[s] + PW'(1);
        end
        if (pop[s]) begin
          rd_ptr_q[s] <= rd_ptr_q[s] + PW'(1);
        end
        cnt_q[s] <= cnt_q[s] + CW'(wr_en[s]) - CW'(pop[s]);
        if (wvalid[s] && full[s]) begin
          drop_q[s] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    burst_d = burst_q;
    pop     = '0;
    unique case (state_q)
      S_IDLE: begin
        burst_d = '0;
        if (nonempty[0] && nonempty[1]) begin
          state_d = prio_q ? S_GRANT1 : S_GRANT0;
        end else if (nonempty[0]) begin
          state_d = S_GRANT0;
        end else if (nonempty[1]) begin
          state_d = S_GRANT1;
        end
      end
      S_GRANT0, S_GRANT1: begin
        pop[gnt_src] = 1'b1;
        prio_d       = ~gnt_src;
        if (other_ne && (last_word || burst_end)) begin
          state_d = gnt_src ? S_GRANT0 : S_GRANT1;
          burst_d = '0;
        end else if (last_word) begin
          // Exit even if this source is written on the same edge: one bubble.
          state_d = S_IDLE;
          burst_d = '0;
        end else if (burst_end) begin
          burst_d = '0;
        end else begin
          burst_d = burst_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= 1'b0;
    end else begin
      out_valid_q <= |pop;
      if (|pop) begin
        out_data_q <= mem_q[gnt_src][rd_ptr_q[gnt_src]];
        out_sel_q  <= gnt_src;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.in0_full  = full[0];
  assign bus.in1_full  = full[1];
  assign bus.in0_drop  = drop_q[0];
  assign bus.in1_drop  = drop_q[1];

endmodule

// File: tb/tb_arb_mux21_2b.sv
// Bench for arb_mux21_2b: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference of the arbitration rules.
module tb_arb_mux21_2b;

  localparam int DEPTH = 4;
  localparam int BURST = 2;

  logic clk;
  logic reset;

  arb_mux21_2b_if bus ();

  arb_mux21_2b #(.DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [1:0] mq0 [$];
  logic [1:0] mq1 [$];
  int         m_owner;
  int         m_served;
  int         m_prio;
  logic       m_drop0, m_drop1;
  logic       m_valid, m_sel;
  logic [1:0] m_data;

  logic [3:0] trace [$];

  logic [3:0] exp_ss [6]  = '{4'b0000, 4'b0000, 4'b1001, 4'b1010, 4'b1011, 4'b0000};
  logic [3:0] exp_rr [12] = '{4'b0000, 4'b0000, 4'b1000, 4'b1001, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1101, 4'b1100, 4'b0000, 4'b0000};

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_owner  = -1;
    m_served = 0;
    m_prio   = 0;
    m_drop0  = 1'b0;
    m_drop1  = 1'b0;
    m_valid  = 1'b0;
    m_sel    = 1'b0;
    m_data   = 2'b00;
  endtask

  task automatic model_step(input logic v0, input logic [1:0] d0,
                            input logic v1, input logic [1:0] d1);
    int n0, n1, c;
    bit o_ne;
    n0 = mq0.size();
    n1 = mq1.size();
    m_valid = 1'b0;
    if (m_owner >= 0) begin
      m_valid = 1'b1;
      m_sel   = (m_owner == 1);
      if (m_owner == 0) m_data = mq0.pop_front();
      else              m_data = mq1.pop_front();
      c      = (m_owner == 0) ? n0 : n1;
      o_ne   = (m_owner == 0) ? (n1 > 0) : (n0 > 0);
      m_prio = 1 - m_owner;
      if (o_ne && (c == 1 || m_served + 1 == BURST)) begin
        m_owner  = 1 - m_owner;
        m_served = 0;
      end else if (c == 1) begin
        m_owner  = -1;
        m_served = 0;
      end else begin
        m_served = (m_served + 1 == BURST) ? 0 : m_served + 1;
      end
    end else begin
      if (n0 > 0 && n1 > 0) m_owner = m_prio;
      else if (n0 > 0)      m_owner = 0;
      else if (n1 > 0)      m_owner = 1;
    end
    if (v0) begin
      if (n0 == DEPTH) m_drop0 = 1'b1;
      else             mq0.push_back(d0);
    end
    if (v1) begin
      if (n1 == DEPTH) m_drop1 = 1'b1;
      else             mq1.push_back(d1);
    end
  endtask

  task automatic check_outputs();
    check_val("out_valid", 8'(bus.out_valid), 8'(m_valid));
    check_val("out_data",  8'(bus.out_data),  8'(m_data));
    check_val("out_sel",   8'(bus.out_sel),   8'(m_sel));
    check_val("in0_full",  8'(bus.in0_full),  8'(mq0.size() == DEPTH));
    check_val("in1_full",  8'(bus.in1_full),  8'(mq1.size() == DEPTH));
    check_val("in0_drop",  8'(bus.in0_drop),  8'(m_drop0));
    check_val("in1_drop",  8'(bus.in1_drop),  8'(m_drop1));
    trace.push_back(bus.out_valid ? {1'b1, bus.out_sel, bus.out_data} : 4'b0000);
  endtask

  task automatic check_zero(input string tag);
    logic [9:0] outs;
    outs = {bus.out_data, bus.out_valid, bus.out_sel,
            bus.in0_full, bus.in1_full, bus.in0_drop, bus.in1_drop, 2'b00};
    check_val(tag, outs[9:2], 8'h00);
  endtask

  // Called at a falling edge; drives, lets one rising edge pass, then checks.
  task automatic cycle(input logic v0, input logic [1:0] d0,
                       input logic v1, input logic [1:0] d1);
    bus.in0_valid = v0;
    bus.in0       = d0;
    bus.in1_valid = v1;
    bus.in1       = d1;
    @(posedge clk);
    model_step(v0, d0, v1, d1);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic apply_reset();
    #2;
    reset         = 1'b0;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    #1;
    check_zero("async_reset_outputs");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    check_outputs();
  endtask

  initial begin
    int   w_idx, words, pos, found, resume_sel;
    logic seen_full0, seen_full1;

    bus.in0       = 2'b00;
    bus.in0_valid = 1'b0;
    bus.in1       = 2'b00;
    bus.in1_valid = 1'b0;
    reset         = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b1;
    check_outputs();

    // single source: in0 = 1,2,3
    trace.delete();
    cycle(1'b1, 2'd1, 1'b0, 2'd0);
    cycle(1'b1, 2'd2, 1'b0, 2'd0);
    cycle(1'b1, 2'd3, 1'b0, 2'd0);
    repeat (3) cycle(1'b0, 2'd0, 1'b0, 2'd0);
    for (int i = 0; i < 6; i++) check_val("single_src_trace", 8'(trace[i]), 8'(exp_ss[i]));

    // round robin from a fresh priority pointer
    apply_reset();
    trace.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 1'b1, 2'(3 - i));
    repeat (8) cycle(1'b0, 2'd0, 1'b0, 2'd0);
    for (int i = 0; i < 12; i++) check_val("round_robin_trace", 8'(trace[i]), 8'(exp_rr[i]));

    // reset mid-burst with both FIFOs partly filled
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 1'b1, 2'(i));
    repeat (2) cycle(1'b0, 2'd0, 1'b0, 2'd0);
    apply_reset();
    trace.delete();
    repeat (6) cycle(1'b0, 2'd0, 1'b0, 2'd0);
    foreach (trace[i]) check_val("no_stale_after_reset", 8'(trace[i]), 8'h00);

    // overflow, including full-edge drops; model tracks the count afterwards
    apply_reset();
    seen_full0 = 1'b0;
    seen_full1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 2'(i), 1'b1, 2'(i + 1));
      seen_full0 |= bus.in0_full;
      seen_full1 |= bus.in1_full;
    end
    check_val("ovf_full0_seen", 8'(seen_full0), 8'd1);
    check_val("ovf_full1_seen", 8'(seen_full1), 8'd1);
    repeat (12) cycle(1'b0, 2'd0, 1'b0, 2'd0);
    check_val("ovf_drop0_sticky", 8'(bus.in0_drop), 8'd1);
    check_val("ovf_drop1_sticky", 8'(bus.in1_drop), 8'd1);

    // starvation bound: lone in1 word against continuous in0 traffic
    apply_reset();
    trace.delete();
    w_idx = 5;
    for (int i = 0; i < 14; i++) cycle(1'b1, 2'(i), (i == w_idx), 2'b10);
    repeat (6) cycle(1'b0, 2'd0, 1'b0, 2'd0);
    words = 0;
    pos = -1;
    for (int i = w_idx + 1; i < trace.size(); i++) begin
      if (trace[i][3] && pos < 0) begin
        words++;
        if (trace[i][2]) pos = i;
      end
    end
    found = (pos >= 0) ? 1 : 0;
    check_val("starve_in1_seen", 8'(found), 8'd1);
    check_val("starve_in1_word", 8'(found != 0 ? trace[pos] : 4'b0000), 8'(4'b1110));
    check_val("starve_within_bound", 8'(words <= BURST + 1), 8'd1);
    resume_sel = -1;
    if (pos >= 0) begin
      for (int i = pos + 1; i < trace.size(); i++) begin
        if (trace[i][3] && resume_sel < 0) resume_sel = trace[i][2];
      end
    end
    check_val("starve_in0_resumes", 8'(resume_sel == 0), 8'd1);

    // random traffic with occasional resets
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) apply_reset();
      cycle(($urandom_range(0, 3) != 0), 2'($urandom),
            ($urandom_range(0, 2) == 0), 2'($urandom));
    end
    repeat (12) cycle(1'b0, 2'd0, 1'b0, 2'd0);
    check_val("drain_q0_empty_model", 8'(bus.in0_full), 8'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/arb_mux21_2b.md
# arb_mux21_2b

Two-requester, round-robin front end for the 2-bit 2:1 data mux path. Each source pushes valid-qualified 2-bit words into its own small FIFO. A three-state arbiter grants the shared output in bounded bursts. The block drives registered data, valid and source-select outputs, which replace the free-running `select` stimulus used on the bare mux.

## Interface
- `DEPTH`, 4: entries per input FIFO; a power of two, at least 2.
- `BURST`, 2: maximum consecutive pops per grant while the other source waits; at least 1.

- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in0`  in  2  source 0 data word
- `in0_valid`  in  1  write strobe for `in0`
- `in1`  in  2  source 1 data word
- `in1_valid`  in  1  write strobe for `in1`
- `out_data`  out  2  registered popped word
- `out_valid`  out  1  high for exactly one cycle per popped word
- `out_sel`  out  1  source of `out_data` (0 = in0, 1 = in1)
- `in0_full`, `in1_full`  out  1 each  FIFO count equals DEPTH
- `in0_drop`, `in1_drop`  out  1 each  sticky flag: a write was discarded while full

## Operation
- **Reset** (`reset`=0, takes effect immediately, not on a clock edge):
  - FIFOs flushed.
  - State goes to IDLE; priority pointer set to in0; burst count 0.
  - All outputs 0.
  - Applies equally mid-burst. Nothing is retained.
- **FIFO write**: `inX_valid`=1 at an edge with `inX_full`=0 stores the word.
  - If `inX_full`=1 the word is discarded and `inX_drop` is set. This holds even when a pop of X occurs on the same edge.
  - `inX_drop` clears only on reset.
- **Full flags**: `inX_full` is decoded from the registered count. The count is DEPTH+1 wide; pointers wrap modulo DEPTH.
- **States**: IDLE, GRANT0, GRANT1. In GRANTx, FIFO x pops one word every cycle.
- **Transitions from IDLE**:
  - Both FIFOs non-empty: go to GRANT of the priority pointer.
  - One non-empty: go to GRANT of that source.
  - Neither: stay in IDLE.
- **Transitions from GRANTx**, with `c` = count of x before this pop and `o` = other FIFO non-empty:
  - `o` and (`c`=1 or burst+1=BURST): go to GRANTother, burst 0.
  - `c`=1 and not `o`: go to IDLE. This applies even if x is written on the same edge; a one-cycle bubble results.
  - Otherwise: stay in GRANTx. burst increments, or resets to 0 when it reaches BURST with the other source empty.
- **Priority pointer**: after every pop it points to the source not just served.
- **Output**: on each pop, `out_data`, `out_sel` and `out_valid`=1 load at the same edge.
  - With no pop, `out_valid`=0 and `out_data`/`out_sel` hold their last values.
- **Ordering**: words from each source leave in write order, with no duplication and no loss except flagged drops.

## Timing
- **Latency, from IDLE**: write at edge k, then state GRANTx at edge k+1, then `out_valid`=1 after edge k+2.
- **Throughput**: one word per cycle while any FIFO holds data, apart from the IDLE re-entry bubble.
- **Handover**: the switch between sources costs no cycles. The last pop of one source and the first pop of the other are on consecutive edges.
- **Fairness**: a waiting word at the head of FIFO y appears within BURST+1 output words once y is non-empty and the arbiter is in GRANTx.
- **Combinational paths**: none from inputs to outputs. The full flags depend on registered count only.

## Test plan
- **Reset**:
  - Stimulus: pull `reset` low mid-burst with both FIFOs partly filled.
  - Required: all outputs 0 before the next edge; after release, no stale word is ever output.
- **Single source** (DEPTH=4, BURST=2):
  - Stimulus: write in0 = 1, 2, 3 on edges k, k+1, k+2; in1 idle.
  - Required: `out_data` = 1, 2, 3 with `out_sel`=0 after edges k+2, k+3, k+4; then IDLE.
- **Round-robin**:
  - Stimulus: on edges k..k+3, write in0 = 0, 1, 2, 3 and in1 = 3, 2, 1, 0 simultaneously.
  - Required:
    - Output after edges k+2..k+9 is 0, 1, 3, 2, 2, 3, 1, 0.
    - `out_sel` = 0, 0, 1, 1, 0, 0, 1, 1.
    - Then IDLE.
- **Overflow**:
  - Stimulus: both sources valid every cycle for 12 cycles with an incrementing pattern.
  - Required:
    - Both full flags assert.
    - Both drop flags set and stay 1 until reset.
    - Each source's output stream is an in-order subsequence of its writes.
- **Full-edge drop**:
  - Stimulus: write to a full FIFO on the same edge it pops.
  - Required: the word is discarded, the drop flag sets, and the count decrements by 1.
- **Starvation bound** (BURST=2):
  - Stimulus: in0 valid continuously; a single in1 word = 2'b10 arrives.
  - Required: 2'b10 with `out_sel`=1 appears within 3 output words, after which in0 resumes.
